piezo_note_player: RTL and testbench

Consumer of the debounced one-cycle button triggers: each trigger pulse on one of eight lines starts a fixed-length square-wave tone on the piezo, at the pitch assigned to that line (C4 to C5 scale, 1 MHz clock). It sits between the button-debounce/edge stage and the piezo pin. It also exports the active note index for the 7-segment display.

---
 rtl/piezo_note_player_if.sv | 9 +
 rtl/piezo_note_player.sv | 99 +++++++++
 tb/tb_piezo_note_player.sv | 139 +++++++++++++
 3 files changed

// File: rtl/piezo_note_player_if.sv
// piezo_note_player_if: trigger lines in, piezo drive and display status out
interface piezo_note_player_if;
  logic [7:0] trig;
  logic       piezo;
  logic       busy;
  logic [2:0] note_idx;
  modport master (output trig, input piezo, input busy, input note_idx);
  modport slave (input trig, output piezo, output busy, output note_idx);
endinterface

// File: rtl/piezo_note_player.sv
// piezo_note_player: plays a fixed-length square-wave tone for the lowest pending trigger line
module piezo_note_player #(
  parameter logic [19:0] DURATION = 20'd500000,
  parameter logic [15:0] PRESCALE = 16'd1
) (
  input logic clk,
  input logic rst,
  piezo_note_player_if.slave bus
);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t      state_q, state_d;
  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic [10:0] half_cnt_q, half_cnt_d;
  logic [19:0] dur_cnt_q, dur_cnt_d;
  logic [10:0] half_q, half_d;
  logic [2:0]  note_q, note_d;
  logic        piezo_q, piezo_d;
  logic        busy_q, busy_d;
  logic [2:0]  sel;
  logic        tick, half_wrap, dur_end;
  function automatic logic [10:0] half_of(input logic [2:0] n);
    return n == 3'd0 ? 11'd1911 :
           n == 3'd1 ? 11'd1703 :
           n == 3'd2 ? 11'd1517 :
           n == 3'd3 ? 11'd1432 :
           n == 3'd4 ? 11'd1276 :
           n == 3'd5 ? 11'd1136 :
           n == 3'd6 ? 11'd1012 : 11'd956;
  endfunction
  assign tick      = pre_cnt_q == PRESCALE - 16'd1;
  assign half_wrap = half_cnt_q == half_q - 11'd1;
  assign dur_end   = dur_cnt_q == DURATION - 20'd1;
  // lowest set trigger bit selects the note
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) if (bus.trig[i]) sel = 3'(i);
  end
  // a trigger always (re)starts; otherwise advance the tone on each tick
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    half_cnt_d = half_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    half_d     = half_q;
    note_d     = note_q;
    piezo_d    = piezo_q;
    busy_d     = busy_q;
    if (|bus.trig) begin
      state_d    = PLAY;
      note_d     = sel;
      half_d     = half_of(sel);
      pre_cnt_d  = '0;
      half_cnt_d = '0;
      dur_cnt_d  = '0;
      piezo_d    = 1'b0;
      busy_d     = 1'b1;
    end else if (state_q == PLAY) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 16'd1;
      if (tick) begin
        half_cnt_d = half_wrap ? '0 : half_cnt_q + 11'd1;
        piezo_d    = half_wrap ? ~piezo_q : piezo_q;
        dur_cnt_d  = dur_cnt_q + 20'd1;
        if (dur_end) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          piezo_d    = 1'b0;
          pre_cnt_d  = '0;
          half_cnt_d = '0;
          dur_cnt_d  = '0;
        end
      end
    end
  end
  // state and counter registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      half_cnt_q <= '0;
      dur_cnt_q  <= '0;
      half_q     <= '0;
      note_q     <= '0;
      piezo_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      half_cnt_q <= half_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      half_q     <= half_d;
      note_q     <= note_d;
      piezo_q    <= piezo_d;
      busy_q     <= busy_d;
    end
  end
  assign bus.piezo    = piezo_q;
  assign bus.busy     = busy_q;
  assign bus.note_idx = note_q;
endmodule

// File: tb/tb_piezo_note_player.sv
// tb_piezo_note_player: directed checks of tone timing, priority, retrigger and reset
module tb_piezo_note_player;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int bad;
  piezo_note_player_if if1 ();
  piezo_note_player_if if4 ();
  piezo_note_player #(.DURATION(20'd10000), .PRESCALE(16'd1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  piezo_note_player #(.DURATION(20'd10000), .PRESCALE(16'd4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse1(input logic [7:0] t);
    if1.trig = t;
    @(posedge clk);
    @(negedge clk);
    if1.trig = 8'h00;
  endtask
  initial begin
    if1.trig = 8'h00;
    if4.trig = 8'h00;
    adv(3);
    check("rst_piezo", 32'(if1.piezo), 32'd0);
    check("rst_busy", 32'(if1.busy), 32'd0);
    check("rst_note", 32'(if1.note_idx), 32'd0);
    rst = 1'b1;
    adv(20);
    #2 rst = 1'b0;
    #1;
    check("midrst_out", {29'd0, if1.piezo, if1.busy, 1'b0}, 32'd0);
    check("midrst_note", 32'(if1.note_idx), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (if1.piezo !== 1'b0 || if1.busy !== 1'b0 || if1.note_idx !== 3'd0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    // single note 0
    pulse1(8'h01);
    check("n0_busy_e0", 32'(if1.busy), 32'd1);
    check("n0_note_e0", 32'(if1.note_idx), 32'd0);
    check("n0_piezo_e0", 32'(if1.piezo), 32'd0);
    adv(1910);
    check("n0_pz_1910", 32'(if1.piezo), 32'd0);
    adv(1);
    check("n0_pz_1911", 32'(if1.piezo), 32'd1);
    adv(1910);
    check("n0_pz_3821", 32'(if1.piezo), 32'd1);
    adv(1);
    check("n0_pz_3822", 32'(if1.piezo), 32'd0);
    adv(6177);
    check("n0_busy_9999", 32'(if1.busy), 32'd1);
    check("n0_pz_9999", 32'(if1.piezo), 32'd1);
    adv(1);
    check("n0_busy_end", 32'(if1.busy), 32'd0);
    check("n0_pz_end", 32'(if1.piezo), 32'd0);
    check("n0_note_hold", 32'(if1.note_idx), 32'd0);
    // priority and prescale on the PRESCALE=4 instance
    if4.trig = 8'h24;
    @(posedge clk);
    @(negedge clk);
    if4.trig = 8'h00;
    check("p4_note", 32'(if4.note_idx), 32'd2);
    check("p4_busy", 32'(if4.busy), 32'd1);
    check("p4_u1_idle", 32'(if1.busy), 32'd0);
    adv(6067);
    check("p4_pz_6067", 32'(if4.piezo), 32'd0);
    adv(1);
    check("p4_pz_6068", 32'(if4.piezo), 32'd1);
    adv(6067);
    check("p4_pz_12135", 32'(if4.piezo), 32'd1);
    adv(1);
    check("p4_pz_12136", 32'(if4.piezo), 32'd0);
    // retrigger during note 0
    pulse1(8'h01);
    adv(2999);
    check("rt_pz_2999", 32'(if1.piezo), 32'd1);
    pulse1(8'h80);
    check("rt_note", 32'(if1.note_idx), 32'd7);
    check("rt_pz_3000", 32'(if1.piezo), 32'd0);
    check("rt_busy", 32'(if1.busy), 32'd1);
    adv(955);
    check("rt_pz_3955", 32'(if1.piezo), 32'd0);
    adv(1);
    check("rt_pz_3956", 32'(if1.piezo), 32'd1);
    adv(9043);
    check("rt_busy_12999", 32'(if1.busy), 32'd1);
    adv(1);
    check("rt_busy_13000", 32'(if1.busy), 32'd0);
    check("rt_note_hold", 32'(if1.note_idx), 32'd7);
    // trigger on the note-end edge
    pulse1(8'h01);
    adv(9999);
    check("bd_busy_9999", 32'(if1.busy), 32'd1);
    pulse1(8'h10);
    check("bd_busy_10000", 32'(if1.busy), 32'd1);
    check("bd_note", 32'(if1.note_idx), 32'd4);
    check("bd_pz_start", 32'(if1.piezo), 32'd0);
    adv(1275);
    check("bd_pz_1275", 32'(if1.piezo), 32'd0);
    adv(1);
    check("bd_pz_1276", 32'(if1.piezo), 32'd1);
    // asynchronous reset mid-note
    adv(3724);
    check("mr_pz_before", 32'(if1.piezo), 32'd1);
    check("mr_busy_before", 32'(if1.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mr_pz", 32'(if1.piezo), 32'd0);
    check("mr_busy", 32'(if1.busy), 32'd0);
    check("mr_note", 32'(if1.note_idx), 32'd0);
    check("mr_u4_busy", 32'(if4.busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (if1.piezo !== 1'b0 || if1.busy !== 1'b0 || if4.piezo !== 1'b0 || if4.busy !== 1'b0) bad++;
    end
    check("mr_silent", 32'(bad), 32'd0);
    pulse1(8'h02);
    check("mr_new_note", 32'(if1.note_idx), 32'd1);
    check("mr_new_busy", 32'(if1.busy), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
